mmio_switch_in: RTL and testbench

//  Memory-mapped input peripheral: the inbound counterpart to the LED/RGB output path.
//  - Synchronises and debounces the raw board switch SW.
//  - Latches rising/falling-edge events as sticky pending bits, counts rising edges and raises an optional level IRQ.
//  - Sits on the core's data bus beside the LED registers; firmware reads switch state instead of relying on raw pins.

---
 rtl/mmio_pkg.sv | 25 ++
 rtl/sw_debounce.sv | 90 +++++++++
 rtl/mmio_switch_in.sv | 98 +++++++++
 tb/tb_mmio_switch_in.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped switch input block: register offsets,
// debounce FSM states and bit positions within STATUS/CTRL/CLEAR.
package mmio_pkg;

  typedef enum logic [1:0] {
    S_LO      = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HI      = 2'd2,
    S_WAIT_LO = 2'd3
  } debounce_state_t;

  localparam logic [3:0] OFS_STATUS  = 4'h0;
  localparam logic [3:0] OFS_CTRL    = 4'h4;
  localparam logic [3:0] OFS_CLEAR   = 4'h8;
  localparam logic [3:0] OFS_EDGECNT = 4'hC;

  localparam int STAT_LEVEL_BIT   = 0;
  localparam int STAT_RISE_BIT    = 1;
  localparam int STAT_FALL_BIT    = 2;
  localparam int CTRL_RISE_EN_BIT = 0;
  localparam int CTRL_FALL_EN_BIT = 1;

  localparam int EDGECNT_W = 16;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus debounce FSM; a level change is accepted only after the
// synchronised input holds the new value for DEBOUNCE_CYCLES consecutive cycles.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in_i,
  output logic level_o,
  output logic rise_pulse_o,
  output logic fall_pulse_o
);
  import mmio_pkg::*;

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            s1_q, s2_q;
  debounce_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_pulse, fall_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= S_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      s1_q    <= sw_in_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Pulses are combinational so the top can register them on the same edge level flips.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    rise_pulse = 1'b0;
    fall_pulse = 1'b0;
    case (state_q)
      S_LO: begin
        if (s2_q) begin
          state_d = S_WAIT_HI;
          cnt_d   = '0;
        end
      end
      S_WAIT_HI: begin
        if (!s2_q) begin
          state_d = S_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = S_HI;
          level_d    = 1'b1;
          rise_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HI: begin
        if (!s2_q) begin
          state_d = S_WAIT_LO;
          cnt_d   = '0;
        end
      end
      S_WAIT_LO: begin
        if (s2_q) begin
          state_d = S_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = S_LO;
          level_d    = 1'b0;
          fall_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_LO;
    endcase
  end

  assign level_o      = level_q;
  assign rise_pulse_o = rise_pulse;
  assign fall_pulse_o = fall_pulse;

endmodule

// File: rtl/mmio_switch_in.sv
// Memory-mapped switch input: debounced level, sticky edge flags, rising-edge counter
// and level IRQ, exposed through a 16-byte register window with OR-able read data.
module mmio_switch_in #(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0010,
  parameter int          DEBOUNCE_CYCLES = 12000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw_in,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  import mmio_pkg::*;

  logic level, rise_pulse, fall_pulse;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk         (clk),
    .rst         (rst),
    .sw_in_i     (sw_in),
    .level_o     (level),
    .rise_pulse_o(rise_pulse),
    .fall_pulse_o(fall_pulse)
  );

  logic [1:0]           ctrl_q, ctrl_d;
  logic                 rise_pend_q, rise_pend_d;
  logic                 fall_pend_q, fall_pend_d;
  logic [EDGECNT_W-1:0] edgecnt_q, edgecnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 irq_q, irq_d;

  logic       sel;
  logic [3:0] ofs;
  logic       wr_ctrl, wr_clear, wr_cnt;
  logic [31:0] rd_mux;
  logic       unused_wdata;

  assign sel      = (addr[31:4] == BASE_ADDR[31:4]);
  assign ofs      = addr[3:0];
  assign wr_ctrl  = wr_en && sel && (ofs == OFS_CTRL);
  assign wr_clear = wr_en && sel && (ofs == OFS_CLEAR);
  assign wr_cnt   = wr_en && sel && (ofs == OFS_EDGECNT);
  assign unused_wdata = ^wdata[31:3];

  always_comb begin
    rd_mux = '0;
    case (ofs)
      OFS_STATUS:  rd_mux = {29'd0, fall_pend_q, rise_pend_q, level};
      OFS_CTRL:    rd_mux = {30'd0, ctrl_q};
      OFS_EDGECNT: rd_mux = {{(32-EDGECNT_W){1'b0}}, edgecnt_q};
      default:     rd_mux = '0;
    endcase
  end

  // A new edge event overrides a CLEAR landing on the same cycle; an EDGECNT write overrides a rise.
  always_comb begin
    ctrl_d      = wr_ctrl ? wdata[1:0] : ctrl_q;
    rise_pend_d = rise_pulse | (rise_pend_q & ~(wr_clear & wdata[STAT_RISE_BIT]));
    fall_pend_d = fall_pulse | (fall_pend_q & ~(wr_clear & wdata[STAT_FALL_BIT]));
    edgecnt_d   = edgecnt_q;
    if (wr_cnt) begin
      edgecnt_d = '0;
    end else if (rise_pulse) begin
      edgecnt_d = edgecnt_q + EDGECNT_W'(1);
    end
    irq_d   = (rise_pend_q & ctrl_q[CTRL_RISE_EN_BIT]) | (fall_pend_q & ctrl_q[CTRL_FALL_EN_BIT]);
    rdata_d = (rd_en && sel) ? rd_mux : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q      <= '0;
      rise_pend_q <= 1'b0;
      fall_pend_q <= 1'b0;
      edgecnt_q   <= '0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      rise_pend_q <= rise_pend_d;
      fall_pend_q <= fall_pend_d;
      edgecnt_q   <= edgecnt_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_mmio_switch_in.sv
// Directed bench for mmio_switch_in with a 4-cycle debounce; inputs change on the
// falling clock edge and outputs are sampled there too.
module tb_mmio_switch_in;

  localparam logic [31:0] BASE = 32'hFFFF_0010;
  localparam logic [31:0] A_STATUS  = BASE + 32'h0;
  localparam logic [31:0] A_CTRL    = BASE + 32'h4;
  localparam logic [31:0] A_CLEAR   = BASE + 32'h8;
  localparam logic [31:0] A_EDGECNT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sw_in = 1'b0;
  logic [31:0] addr = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int tests = 0;
  int fails = 0;
  logic [31:0] rd;

  mmio_switch_in #(
    .BASE_ADDR      (BASE),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .sw_in(sw_in),
    .addr (addr),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    // 1. reset and idle
    tick(3);
    rst = 1'b0;
    tick(10);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("idle_rdata", rdata, 32'd0);
    bus_read(A_STATUS, rd);  check("reset_status", rd, 32'h0);
    bus_read(A_EDGECNT, rd); check("reset_edgecnt", rd, 32'h0);
    bus_read(A_CTRL, rd);    check("reset_ctrl", rd, 32'h0);

    // 2. debounced rise latency: level flips on the 7th edge
    sw_in = 1'b1;
    tick(6); check("rise_lat_e6", {31'd0, dut.u_deb.level_q}, 32'd0);
    tick(1); check("rise_lat_e7", {31'd0, dut.u_deb.level_q}, 32'd1);
    bus_read(A_STATUS, rd);  check("rise_status", rd, 32'h3);
    bus_read(A_EDGECNT, rd); check("rise_edgecnt", rd, 32'h1);
    bus_write(A_CLEAR, 32'h2);
    bus_read(A_STATUS, rd);  check("clear_rise", rd, 32'h1);
    sw_in = 1'b0;
    tick(10);
    bus_read(A_STATUS, rd);  check("fall_status", rd, 32'h4);
    bus_read(A_EDGECNT, rd); check("fall_edgecnt", rd, 32'h1);
    bus_write(A_CLEAR, 32'h4);
    bus_write(A_EDGECNT, 32'h1234);
    bus_read(A_EDGECNT, rd); check("edgecnt_wr_zero", rd, 32'h0);

    // 3. glitches: 2-cycle pulse and the longest rejected pulse (4 cycles)
    sw_in = 1'b1; tick(2); sw_in = 1'b0; tick(10);
    bus_read(A_STATUS, rd);  check("glitch2_status", rd, 32'h0);
    sw_in = 1'b1; tick(4); sw_in = 1'b0; tick(10);
    bus_read(A_STATUS, rd);  check("glitch4_status", rd, 32'h0);
    bus_read(A_EDGECNT, rd); check("glitch_edgecnt", rd, 32'h0);

    // 4. irq on rise, clear, fall with fall irq disabled
    bus_write(A_CTRL, 32'h1);
    bus_read(A_CTRL, rd); check("ctrl_rd", rd, 32'h1);
    sw_in = 1'b1;
    tick(7); check("irq_same_edge", {31'd0, irq}, 32'd0);
    tick(1); check("irq_assert", {31'd0, irq}, 32'd1);
    bus_write(A_CLEAR, 32'h2);
    check("irq_hold_after_clr", {31'd0, irq}, 32'd1);
    tick(1); check("irq_deassert", {31'd0, irq}, 32'd0);
    sw_in = 1'b0;
    tick(10); check("irq_fall_masked", {31'd0, irq}, 32'd0);
    bus_read(A_STATUS, rd); check("fall_pend_set", rd, 32'h4);
    bus_write(A_CLEAR, 32'h4);

    // 5. clear coinciding with rise, counter wrap, EDGECNT write coinciding with rise
    sw_in = 1'b1;
    tick(6);
    bus_write(A_CLEAR, 32'h2);
    bus_read(A_STATUS, rd); check("set_beats_clear", rd, 32'h3);
    bus_write(A_CLEAR, 32'h2);
    sw_in = 1'b0;
    tick(10);
    bus_write(A_CLEAR, 32'h4);
    force dut.edgecnt_q = 16'hFFFF;
    #1 release dut.edgecnt_q;
    tick(1);
    bus_read(A_EDGECNT, rd); check("edgecnt_preload", rd, 32'h0000_FFFF);
    sw_in = 1'b1;
    tick(10);
    bus_read(A_EDGECNT, rd); check("edgecnt_wrap", rd, 32'h0);
    bus_write(A_CLEAR, 32'h2);
    sw_in = 1'b0;
    tick(10);
    bus_write(A_CLEAR, 32'h4);
    sw_in = 1'b1;
    tick(6);
    bus_write(A_EDGECNT, 32'h0);
    bus_read(A_EDGECNT, rd); check("edgecnt_wr_wins", rd, 32'h0);
    bus_read(A_STATUS, rd);  check("rise_with_cntwr", rd, 32'h3);
    bus_write(A_CLEAR, 32'h2);

    // bus corner cases
    addr = A_CTRL; wdata = 32'h2; rd_en = 1'b1; wr_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    check("rdwr_pre_value", rdata, 32'h1);
    bus_read(A_CTRL, rd); check("rdwr_post_value", rd, 32'h2);
    bus_write(BASE + 32'h24, 32'h1);
    bus_read(A_CTRL, rd); check("wr_outside_ignored", rd, 32'h2);
    bus_read(BASE + 32'h1, rd);     check("unmapped_ofs", rd, 32'h0);
    bus_read(A_CLEAR, rd);          check("clear_reads_0", rd, 32'h0);
    bus_read(BASE - 32'h10, rd);    check("unselected_rd", rd, 32'h0);

    // 6. reset mid-debounce, then a full debounce after release
    sw_in = 1'b0;
    tick(10);
    bus_write(A_CLEAR, 32'h6);
    sw_in = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    check("rst_level", {31'd0, dut.u_deb.level_q}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    tick(6); check("post_rst_e6", {31'd0, dut.u_deb.level_q}, 32'd0);
    tick(1); check("post_rst_e7", {31'd0, dut.u_deb.level_q}, 32'd1);
    bus_read(A_STATUS, rd);  check("post_rst_status", rd, 32'h3);
    bus_read(A_EDGECNT, rd); check("post_rst_edgecnt", rd, 32'h1);
    bus_read(A_CTRL, rd);    check("post_rst_ctrl", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
